// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter.
//   arb_state_t : access sequencer states
//   owner_t     : which requester owns the access in flight
//   SIZE_WORD   : funct3 size code used for every instruction fetch
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Memory latency counter: loads MEM_LAT-1 and counts down while dec is high.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   load     : load MEM_LAT-1
//   dec      : decrement (saturates at 0)
//   zero     : the decrement in this cycle brings the count to zero
module lat_counter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  logic [CNT_W-1:0] count;

  // Count register; load has priority over decrement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(MEM_LAT - 1);
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  // Looking one step ahead lets the FSM register the response pulse on time.
  assign zero = (count == CNT_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. Each access runs IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE;
// stores complete in ISSUE. Exactly one valid pulse per grant.
// Configuration macro: ARB_RR_EN (round-robin on simultaneous requests;
// undefined = data port always wins).
// Ports:
//   clk, rst                   : clock, asynchronous active-high reset
//   if_req/if_addr             : fetch request, held until if_valid
//   if_rdata/if_valid          : fetch response (rdata 0 outside valid)
//   dm_req/dm_we/dm_size/
//   dm_addr/dm_wdata           : data request, held until dm_valid
//   dm_rdata/dm_valid          : data response (load data or store done)
//   mem_en/mem_we/mem_size/
//   mem_addr/mem_wdata         : registered memory command, one strobe per access
//   mem_rdata                  : memory read data, valid MEM_LAT cycles after mem_en
//   busy                       : sequencer not idle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [2:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [2:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic              grant_dm;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              mem_en_d, mem_we_d;
  logic [2:0]        mem_size_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              if_valid_d, dm_valid_d;
`ifdef ARB_RR_EN
  owner_t            last_q, last_d;
`endif

  lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat_counter (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_size_d  = 3'b000;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if_valid_d  = 1'b0;
    dm_valid_d  = 1'b0;
`ifdef ARB_RR_EN
    last_d      = last_q;
    grant_dm    = dm_req && (!if_req || (last_q == OWN_FETCH));
`else
    grant_dm    = dm_req;
`endif

    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d  = ISSUE;
          mem_en_d = 1'b1;
          if (grant_dm) begin
            owner_d     = OWN_DATA;
            we_d        = dm_we;
            mem_we_d    = dm_we;
            mem_size_d  = dm_size;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            dm_valid_d  = dm_we;
          end else begin
            owner_d    = OWN_FETCH;
            we_d       = 1'b0;
            mem_size_d = SIZE_WORD;
            mem_addr_d = if_addr;
          end
`ifdef ARB_RR_EN
          last_d = owner_d;
`endif
        end
      end

      ISSUE: begin
        if (we_q) begin
          state_d = IDLE;
        end else if (MEM_LAT == 1) begin
          state_d = RESP;
          if (owner_q == OWN_DATA) dm_valid_d = 1'b1;
          else                     if_valid_d = 1'b1;
        end else begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end
      end

      WAIT: begin
        cnt_dec = 1'b1;
        if (cnt_zero) begin
          state_d = RESP;
          if (owner_q == OWN_DATA) dm_valid_d = 1'b1;
          else                     if_valid_d = 1'b1;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_FETCH;
      we_q      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_size  <= 3'b000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_size  <= mem_size_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_valid  <= if_valid_d;
      dm_valid  <= dm_valid_d;
      busy      <= (state_d != IDLE);
    end
  end

`ifdef ARB_RR_EN
  // Last-grant register for round-robin tie breaking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= OWN_FETCH;
    else     last_q <= last_d;
  end
`endif

  // Read data passes straight through from memory during the owner's pulse.
  assign if_rdata = if_valid ? mem_rdata : '0;
  assign dm_rdata = dm_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed MEM_LAT=1 accesses on a second instance,
// then randomized requesters on a MEM_LAT=2 instance checked cycle by cycle
// against a transaction-level model, with resets injected mid-access.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // main instance (MEM_LAT = 2)
  logic        if_req, if_valid, dm_req, dm_we, dm_valid;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [2:0]  dm_size, mem_size;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  // second instance (MEM_LAT = 1)
  logic        l1_if_req, l1_if_valid, l1_dm_req, l1_dm_we, l1_dm_valid;
  logic [31:0] l1_if_addr, l1_if_rdata, l1_dm_addr, l1_dm_wdata, l1_dm_rdata;
  logic [2:0]  l1_dm_size, l1_mem_size;
  logic        l1_mem_en, l1_mem_we, l1_busy;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_valid(l1_if_valid),
    .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_size(l1_dm_size), .dm_addr(l1_dm_addr),
    .dm_wdata(l1_dm_wdata), .dm_rdata(l1_dm_rdata), .dm_valid(l1_dm_valid),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_size(l1_mem_size), .mem_addr(l1_mem_addr),
    .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One isolated access on the MEM_LAT=1 instance; request dropped and
  // scrambled right after grant, which must not affect the access.
  task automatic l1_access(input bit dm, input bit we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    @(posedge clk); #1;                                  // cycle T
    if (dm) begin
      l1_dm_req = 1'b1; l1_dm_we = we; l1_dm_size = size;
      l1_dm_addr = addr; l1_dm_wdata = wdata;
    end else begin
      l1_if_req = 1'b1; l1_if_addr = addr;
    end
    @(posedge clk); #1;                                  // T+1
    l1_if_req = 1'b0; l1_dm_req = 1'b0; l1_dm_we = 1'b0;
    l1_if_addr = 32'hFFFF_FFFF; l1_dm_addr = 32'hFFFF_FFFF; l1_dm_wdata = 32'h0;
    rd = $urandom(); l1_mem_rdata = rd; #1;
    check("l1_en_t1",    l1_mem_en, 1'b1);
    check("l1_we_t1",    l1_mem_we, we);
    check("l1_size_t1",  l1_mem_size, dm ? size : 3'b010);
    check("l1_addr_t1",  l1_mem_addr, addr);
    check("l1_wdata_t1", l1_mem_wdata, dm ? wdata : 32'h0);
    check("l1_dmv_t1",   l1_dm_valid, dm && we);
    check("l1_ifv_t1",   l1_if_valid, 1'b0);
    @(posedge clk); #1;                                  // T+2
    rd = $urandom(); l1_mem_rdata = rd; #1;
    check("l1_en_t2",   l1_mem_en, 1'b0);
    check("l1_dmv_t2",  l1_dm_valid, dm && !we);
    check("l1_ifv_t2",  l1_if_valid, !dm);
    check("l1_busy_t2", l1_busy, !we);
    if (!we) check("l1_rdata_t2", dm ? l1_dm_rdata : l1_if_rdata, rd);
    @(posedge clk); #1; #1;                              // T+3
    check("l1_busy_t3",  l1_busy, 1'b0);
    check("l1_dmv_t3",   l1_dm_valid, 1'b0);
    check("l1_ifv_t3",   l1_if_valid, 1'b0);
    check("l1_dmrd_t3",  l1_dm_rdata, 32'h0);
    check("l1_ifrd_t3",  l1_if_rdata, 32'h0);
  endtask

  // transaction-level model of the main instance
  bit          act;
  int          t0, tv;
  bit          own_dm, t_we;
  logic [31:0] t_addr, t_wdata;
  logic [2:0]  t_size;
`ifdef ARB_RR_EN
  bit          last_dm;
`endif
  bit          pick, en_x, ifv_x, dmv_x, busy_x;
  bit          if_pend, dm_pend, rel_rst;
  int          rst_hits;
  // inputs for the following cycle
  logic        nx_if_req, nx_dm_req, nx_dm_we;
  logic [31:0] nx_if_addr, nx_dm_addr, nx_dm_wdata;
  logic [2:0]  nx_dm_size;

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_size = 0; dm_addr = 0; dm_wdata = 0;
    mem_rdata = 0;
    l1_if_req = 0; l1_if_addr = 0; l1_dm_req = 0; l1_dm_we = 0; l1_dm_size = 0;
    l1_dm_addr = 0; l1_dm_wdata = 0; l1_mem_rdata = 0;
    nx_if_req = 0; nx_if_addr = 0; nx_dm_req = 0; nx_dm_we = 0; nx_dm_size = 0;
    nx_dm_addr = 0; nx_dm_wdata = 0;
    act = 0; t0 = 0; tv = 0; own_dm = 0; t_we = 0; t_addr = 0; t_wdata = 0; t_size = 0;
`ifdef ARB_RR_EN
    last_dm = 0;
`endif
    if_pend = 0; dm_pend = 0; rel_rst = 0; rst_hits = 0;

    #1;
    check("rst_busy",  busy, 1'b0);
    check("rst_en",    mem_en, 1'b0);
    check("rst_ifv",   if_valid, 1'b0);
    check("rst_dmv",   dm_valid, 1'b0);
    check("rst_addr",  mem_addr, 32'h0);
    check("rst_l1en",  l1_mem_en, 1'b0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;

    l1_access(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0);          // load
    l1_access(1'b1, 1'b1, 3'b000, 32'h0000_2000, 32'hDEAD_BEEF);  // store
    l1_access(1'b0, 1'b0, 3'b010, 32'h0000_0100, 32'h0);          // fetch

    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if_req = nx_if_req; if_addr = nx_if_addr;
      dm_req = nx_dm_req; dm_we = nx_dm_we; dm_size = nx_dm_size;
      dm_addr = nx_dm_addr; dm_wdata = nx_dm_wdata;
      if (rel_rst) begin rst = 1'b0; rel_rst = 0; end
      mem_rdata = $urandom(); #1;

      en_x   = act && (c == t0 + 1);
      ifv_x  = act && (c == tv) && !own_dm;
      dmv_x  = act && (c == tv) && own_dm;
      busy_x = act && (c >= t0 + 1) && (c <= tv);
      check("busy",     busy, busy_x);
      check("mem_en",   mem_en, en_x);
      check("mem_we",   mem_we, en_x && t_we);
      check("mem_size", mem_size, en_x ? t_size : 3'b000);
      check("mem_addr", mem_addr, en_x ? t_addr : 32'h0);
      check("mem_wdat", mem_wdata, en_x ? t_wdata : 32'h0);
      check("if_valid", if_valid, ifv_x);
      check("dm_valid", dm_valid, dmv_x);
      check("if_rdata", if_rdata, ifv_x ? mem_rdata : 32'h0);
      check("dm_rdata", dm_rdata, dmv_x ? mem_rdata : 32'h0);

      if (act && !t_we && (c == t0 + 2) && (rst_hits < 3) && (c > 400 * (rst_hits + 1))) begin
        // abort a load/fetch while it waits on memory
        rst = 1'b1; #1;
        check("arst_busy", busy, 1'b0);
        check("arst_en",   mem_en, 1'b0);
        check("arst_addr", mem_addr, 32'h0);
        check("arst_ifv",  if_valid, 1'b0);
        check("arst_dmv",  dm_valid, 1'b0);
        check("arst_ifrd", if_rdata, 32'h0);
        check("arst_dmrd", dm_rdata, 32'h0);
        act = 0; if_pend = 0; dm_pend = 0;
`ifdef ARB_RR_EN
        last_dm = 0;
`endif
        nx_if_req = 0; nx_dm_req = 0;
        rel_rst = 1; rst_hits++;
      end else begin
        // arbiter free this cycle: grant from the requests it sees now
        if (!act || c > tv) begin
          act = 0;
          if (if_req || dm_req) begin
`ifdef ARB_RR_EN
            pick = dm_req && (!if_req || !last_dm);
            last_dm = pick;
`else
            pick = dm_req;
`endif
            act = 1; t0 = c; own_dm = pick;
            t_we    = pick && dm_we;
            t_addr  = pick ? dm_addr : if_addr;
            t_size  = pick ? dm_size : 3'b010;
            t_wdata = pick ? dm_wdata : 32'h0;
            tv      = t_we ? c + 1 : c + 1 + LAT;
          end
        end

        // data requester
        if (dmv_x) dm_pend = 0;
        if (!dm_pend) begin
          nx_dm_req   = 1'($urandom_range(0, 1));
          dm_pend     = nx_dm_req;
          nx_dm_we    = 1'($urandom_range(0, 1));
          nx_dm_size  = 3'($urandom_range(0, 7));
          nx_dm_addr  = $urandom();
          nx_dm_wdata = $urandom();
        end else if (act && own_dm) begin
          case ($urandom_range(0, 3))
            0: nx_dm_req = 1'b0;
            1: begin nx_dm_addr = $urandom(); nx_dm_wdata = $urandom(); nx_dm_we = ~nx_dm_we; end
            default: ;
          endcase
        end

        // fetch requester
        if (ifv_x) if_pend = 0;
        if (!if_pend) begin
          nx_if_req  = 1'($urandom_range(0, 1));
          if_pend    = nx_if_req;
          nx_if_addr = $urandom() & 32'hFFFF_FFFC;
        end else if (act && !own_dm) begin
          case ($urandom_range(0, 3))
            0: nx_if_req = 1'b0;
            1: nx_if_addr = $urandom() & 32'hFFFF_FFFC;
            default: ;
          endcase
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
